blink_seq_ctrl: RTL and testbench

//  Pattern scheduler for the LED/7-seg blink datapath. Replaces the fixed 1 Hz on/off

---
 rtl/de0_blink_pkg.sv | 61 ++++++
 rtl/key_debounce.sv | 59 +++++
 rtl/blink_seq_ctrl.sv | 110 +++++++++++
 tb/tb_blink_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/de0_blink_pkg.sv
// rtl/de0_blink_pkg.sv - shared encodings and pattern helpers for the blink scheduler
// Purpose: mode/state encodings, per-mode pattern periods, and the mode/step -> pattern decode.
// Contents: mode_e, state_e, pattern_t, period_of(), decode().
package de0_blink_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_STEADY = 2'd3
  } mode_e;

  typedef enum logic {
    STATE_RUN   = 1'b0,
    STATE_PAUSE = 1'b1
  } state_e;

  localparam logic [2:0] PERIOD_BLINK  = 3'd2;
  localparam logic [2:0] PERIOD_CHASE  = 3'd4;
  localparam logic [2:0] PERIOD_FILL   = 3'd5;
  localparam logic [2:0] PERIOD_STEADY = 3'd1;

  typedef struct packed {
    logic       led;
    logic [3:0] dig;
  } pattern_t;

  function automatic logic [2:0] period_of(input mode_e m);
    case (m)
      MODE_BLINK:  return PERIOD_BLINK;
      MODE_CHASE:  return PERIOD_CHASE;
      MODE_FILL:   return PERIOD_FILL;
      default:     return PERIOD_STEADY;
    endcase
  endfunction

  function automatic pattern_t decode(input mode_e m, input logic [2:0] s);
    pattern_t p;
    case (m)
      MODE_BLINK: begin
        p.led = s[0];
        p.dig = {4{s[0]}};
      end
      MODE_CHASE: begin
        p.led = (s == 3'd0);
        p.dig = 4'b0001 << s[1:0];
      end
      MODE_FILL: begin
        // Thermometer fill: step n lights the lowest n digits.
        p.led = (s == 3'd4);
        p.dig = 4'((5'd1 << s) - 5'd1);
      end
      default: begin
        p.led = 1'b1;
        p.dig = 4'b1111;
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-key synchronizer, debouncer and press-pulse generator
// Purpose: turns a raw active-low key into a single-cycle press pulse.
// Ports:
//   clk_i    in  system clock
//   rst_i    in  async active-high reset (debounced level resets to released)
//   nkey_i   in  raw active-low key, asynchronous to clk_i
//   press_o  out one-cycle pulse on the debounced high->low edge
module key_debounce #(
  parameter int DEB_CYC = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic nkey_i,
  output logic press_o
);

  localparam int CNT_W = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC + 1);

  logic             sync1_q, sync2_q, deb_q, press_q;
  logic             deb_d, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             differ, settle;

  // The counter only runs while the synchronized level disagrees with the
  // debounced one; any return to agreement restarts the stability window.
  assign differ = (sync2_q != deb_q);
  assign settle = differ && (cnt_q == CNT_W'(DEB_CYC - 1));

  always_comb begin
    cnt_d   = '0;
    deb_d   = deb_q;
    press_d = 1'b0;
    if (settle) begin
      deb_d   = sync2_q;
      press_d = ~sync2_q;
    end else if (differ) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= nkey_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/blink_seq_ctrl.sv
// rtl/blink_seq_ctrl.sv - four-pattern LED/7-seg blink scheduler with mode and pause keys
// Purpose: prescaler, RUN/PAUSE FSM, mode/step registers and pattern decode.
// Ports:
//   clk_i         in  system clock
//   rst_i         in  async active-high reset
//   nkey_mode_i   in  raw active-low mode key
//   nkey_pause_i  in  raw active-low pause key
//   led_on_o      out LED drive request
//   digit_en_o    out per-digit enable, bit i -> seven-segment digit i
//   mode_o        out current mode (BLINK, CHASE, FILL, STEADY)
//   step_o        out step index within the pattern
//   tick_o        out one-cycle pulse while the freshly advanced step is shown
//   paused_o      out high while in PAUSE
module blink_seq_ctrl
  import de0_blink_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 4,
  parameter int DEB_MS  = 20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       nkey_mode_i,
  input  logic       nkey_pause_i,
  output logic       led_on_o,
  output logic [3:0] digit_en_o,
  output logic [1:0] mode_o,
  output logic [2:0] step_o,
  output logic       tick_o,
  output logic       paused_o
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int DEB_CYC  = CLK_HZ / 1000 * DEB_MS;
  localparam int PSC_W    = $clog2(TICK_DIV);
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(TICK_DIV - 1);

  logic mode_ev, pause_ev;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .nkey_i  (nkey_mode_i),
    .press_o (mode_ev)
  );

  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_pause (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .nkey_i  (nkey_pause_i),
    .press_o (pause_ev)
  );

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [2:0]       step_q, step_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             tick_q, tick_d;
  pattern_t         pat;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    step_d  = step_q;
    psc_d   = psc_q;
    tick_d  = 1'b0;
    if (pause_ev) begin
      state_d = (state_q == STATE_RUN) ? STATE_PAUSE : STATE_RUN;
    end
    // A mode change restarts the pattern and suppresses a coincident wrap.
    if (mode_ev) begin
      mode_d = mode_e'(mode_q + 2'd1);
      step_d = '0;
      psc_d  = '0;
    end else if (state_q == STATE_RUN) begin
      if (psc_q == PSC_MAX) begin
        psc_d  = '0;
        tick_d = 1'b1;
        step_d = (step_q == period_of(mode_q) - 3'd1) ? 3'd0 : step_q + 3'd1;
      end else begin
        psc_d = psc_q + PSC_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= STATE_RUN;
      mode_q  <= MODE_BLINK;
      step_q  <= '0;
      psc_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      psc_q   <= psc_d;
      tick_q  <= tick_d;
    end
  end

  assign pat        = decode(mode_q, step_q);
  assign led_on_o   = pat.led;
  assign digit_en_o = pat.dig;
  assign mode_o     = mode_q;
  assign step_o     = step_q;
  assign tick_o     = tick_q;
  assign paused_o   = (state_q == STATE_PAUSE);

endmodule

// File: tb/tb_blink_seq_ctrl.sv
// tb/tb_blink_seq_ctrl.sv - scoreboard bench for blink_seq_ctrl
module tb_blink_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       nkey_mode = 1'b1;
  logic       nkey_pause = 1'b1;
  logic       led_on;
  logic [3:0] digit_en;
  logic [1:0] mode;
  logic [2:0] step;
  logic       tick;
  logic       paused;

  int          errors = 0;
  int          checks = 0;
  logic [11:0] exp_q[$];
  logic [11:0] e;

  blink_seq_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .DEB_MS(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .nkey_mode_i  (nkey_mode),
    .nkey_pause_i (nkey_pause),
    .led_on_o     (led_on),
    .digit_en_o   (digit_en),
    .mode_o       (mode),
    .step_o       (step),
    .tick_o       (tick),
    .paused_o     (paused)
  );

  always #5 clk = ~clk;

  // Expected output vector {led, digit_en, mode, step, paused, tick} from the pattern tables.
  function automatic logic [11:0] pat(input logic [1:0] m, input logic [2:0] s,
                                      input logic p, input logic t);
    logic       l;
    logic [3:0] d;
    case (m)
      2'd0: begin
        d = (s == 3'd1) ? 4'b1111 : 4'b0000;
        l = (s == 3'd1);
      end
      2'd1: begin
        case (s)
          3'd0:    d = 4'b0001;
          3'd1:    d = 4'b0010;
          3'd2:    d = 4'b0100;
          default: d = 4'b1000;
        endcase
        l = (s == 3'd0);
      end
      2'd2: begin
        case (s)
          3'd0:    d = 4'b0000;
          3'd1:    d = 4'b0001;
          3'd2:    d = 4'b0011;
          3'd3:    d = 4'b0111;
          default: d = 4'b1111;
        endcase
        l = (s == 3'd4);
      end
      default: begin
        d = 4'b1111;
        l = 1'b1;
      end
    endcase
    return {l, d, m, s, p, t};
  endfunction

  function automatic logic [11:0] obs();
    return {led_on, digit_en, mode, step, paused, tick};
  endfunction

  // Stimulus only: holds one key low for 6 cycles then high for 6 cycles.
  // The press event lands on the 5th rising edge after the call.
  task automatic press(input bit pause_key);
    if (pause_key) nkey_pause = 1'b0; else nkey_mode = 1'b0;
    repeat (6) @(negedge clk);
    if (pause_key) nkey_pause = 1'b1; else nkey_mode = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    exp_q.push_back(pat(2'd0, 3'd0, 1'b0, 1'b0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_state: got %h expected %h", obs(), e); end
  endtask

  task automatic test_blink();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pat(2'd0, 3'(i % 2), 1'b0, 1'b0));
      exp_q.push_back(pat(2'd0, 3'((i + 1) % 2), 1'b0, 1'b1));
      repeat (9) @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL blink_hold[%0d]: got %h expected %h", i, obs(), e); end
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL blink_tick[%0d]: got %h expected %h", i, obs(), e); end
    end
  endtask

  task automatic test_mode_key();
    exp_q.push_back(pat(2'd1, 3'd0, 1'b0, 1'b0));
    exp_q.push_back(pat(2'd1, 3'd0, 1'b0, 1'b0));
    for (int j = 1; j <= 4; j++) begin
      exp_q.push_back(pat(2'd1, 3'(j % 4), 1'b0, 1'b1));
      exp_q.push_back(pat(2'd1, 3'(j % 4), 1'b0, 1'b0));
    end
    nkey_mode = 1'b0;
    repeat (6) @(negedge clk);
    nkey_mode = 1'b1;
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL mode_event: got %h expected %h", obs(), e); end
    repeat (8) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL chase_hold0: got %h expected %h", obs(), e); end
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL chase_tick[%0d]: got %h expected %h", j, obs(), e); end
      repeat (9) @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL chase_hold[%0d]: got %h expected %h", j, obs(), e); end
    end
  endtask

  task automatic test_async_reset();
    exp_q.push_back(pat(2'd0, 3'd0, 1'b0, 1'b0));
    exp_q.push_back(pat(2'd0, 3'd0, 1'b0, 1'b0));
    exp_q.push_back(pat(2'd0, 3'd0, 1'b0, 1'b0));
    exp_q.push_back(pat(2'd0, 3'd1, 1'b0, 1'b1));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL async_reset: got %h expected %h", obs(), e); end
    repeat (2) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_hold: got %h expected %h", obs(), e); end
    rst = 1'b0;
    repeat (9) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL post_reset_hold: got %h expected %h", obs(), e); end
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL post_reset_tick: got %h expected %h", obs(), e); end
  endtask

  task automatic test_glitch();
    exp_q.push_back(pat(2'd0, 3'd1, 1'b0, 1'b0));
    exp_q.push_back(pat(2'd0, 3'd1, 1'b0, 1'b0));
    exp_q.push_back(pat(2'd0, 3'd0, 1'b0, 1'b1));
    exp_q.push_back(pat(2'd0, 3'd1, 1'b0, 1'b1));
    nkey_mode = 1'b0;
    @(negedge clk);
    nkey_mode = 1'b1;
    repeat (3) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL glitch: got %h expected %h", obs(), e); end
    for (int k = 0; k < 4; k++) begin
      nkey_mode = (k % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL bounce: got %h expected %h", obs(), e); end
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL bounce_tick: got %h expected %h", obs(), e); end
    repeat (10) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL bounce_late: got %h expected %h", obs(), e); end
  endtask

  task automatic test_pause();
    int bad;
    exp_q.push_back(pat(2'd2, 3'd0, 1'b0, 1'b0));
    exp_q.push_back(pat(2'd2, 3'd1, 1'b0, 1'b0));
    exp_q.push_back(pat(2'd2, 3'd2, 1'b1, 1'b0));
    exp_q.push_back(pat(2'd2, 3'd2, 1'b1, 1'b0));
    exp_q.push_back(pat(2'd2, 3'd2, 1'b0, 1'b0));
    exp_q.push_back(pat(2'd2, 3'd2, 1'b0, 1'b0));
    exp_q.push_back(pat(2'd2, 3'd3, 1'b0, 1'b1));
    press(1'b0);
    press(1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL fill_entry: got %h expected %h", obs(), e); end
    repeat (12) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL fill_step1: got %h expected %h", obs(), e); end
    press(1'b1);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL paused: got %h expected %h", obs(), e); end
    e = exp_q.pop_front();
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (obs() !== e) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL pause_hold: got %0d deviating cycles expected 0", bad); end
    nkey_pause = 1'b0;
    repeat (5) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL resume: got %h expected %h", obs(), e); end
    nkey_pause = 1'b1;
    repeat (5) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL resume_hold: got %h expected %h", obs(), e); end
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL resume_tick: got %h expected %h", obs(), e); end
  endtask

  task automatic test_collisions();
    exp_q.push_back(pat(2'd3, 3'd0, 1'b0, 1'b0));
    exp_q.push_back(pat(2'd0, 3'd0, 1'b0, 1'b0));
    exp_q.push_back(pat(2'd0, 3'd1, 1'b0, 1'b0));
    exp_q.push_back(pat(2'd1, 3'd0, 1'b0, 1'b0));
    exp_q.push_back(pat(2'd1, 3'd0, 1'b0, 1'b0));
    exp_q.push_back(pat(2'd1, 3'd1, 1'b0, 1'b1));
    exp_q.push_back(pat(2'd2, 3'd0, 1'b1, 1'b0));
    press(1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL steady: got %h expected %h", obs(), e); end
    press(1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL mode_wrap: got %h expected %h", obs(), e); end
    repeat (8) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL pre_collide: got %h expected %h", obs(), e); end
    nkey_mode = 1'b0;
    repeat (5) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL wrap_collide: got %h expected %h", obs(), e); end
    nkey_mode = 1'b1;
    repeat (9) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL collide_hold: got %h expected %h", obs(), e); end
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL collide_tick: got %h expected %h", obs(), e); end
    nkey_mode  = 1'b0;
    nkey_pause = 1'b0;
    repeat (6) @(negedge clk);
    nkey_mode  = 1'b1;
    nkey_pause = 1'b1;
    repeat (6) @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL mode_pause_same: got %h expected %h", obs(), e); end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_mode_key();
    test_async_reset();
    test_glitch();
    test_pause();
    test_collisions();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
